// File: rtl/tug_player_tx.sv
// Press generator for one side of the tug-of-war playfield.
// Button or LFSR opponent requests a press; a lockout window spaces them out.
module tug_player_tx #(
    parameter int LOCKOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       cpu_mode,
    input  logic [9:0] level,
    input  logic       game_over,
    output logic       press,
    output logic [7:0] press_count,
    output logic [9:0] lfsr
);

    localparam int CW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIRE = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t        ps;
    state_t        ns;
    logic [CW-1:0] lock_cnt;
    logic          key_meta;
    logic          key_sync;
    logic          key_prev;
    logic          human_edge;
    logic          cpu_req;
    logic          req;
    logic          lfsr_fb;

    // Button is asynchronous: two flops before anything looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_meta <= ~key_n;
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    assign human_edge = key_sync & ~key_prev;

    // XNOR taps keep all-zeros legal, so reset to 0 is a valid seed.
    assign lfsr_fb = ~(lfsr[9] ^ lfsr[6]);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 10'd0;
        end else begin
            lfsr <= {lfsr[8:0], lfsr_fb};
        end
    end

    assign cpu_req = (lfsr < level);
    assign req     = cpu_mode ? cpu_req : human_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps <= IDLE;
        end else begin
            ps <= ns;
        end
    end

    always_comb begin
        ns = ps;
        unique case (ps)
            IDLE: begin
                if (req && !game_over) begin
                    ns = FIRE;
                end
            end
            FIRE: begin
                ns = LOCK;
            end
            LOCK: begin
                if (lock_cnt == LOCK_LAST) begin
                    ns = IDLE;
                end
            end
            default: begin
                ns = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (ps == FIRE) begin
            lock_cnt <= '0;
        end else if (ps == LOCK) begin
            lock_cnt <= lock_cnt + CW'(1);
        end
    end

    assign press = (ps == FIRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= 8'd0;
        end else if (press && press_count != 8'hff) begin
            press_count <= press_count + 8'd1;
        end
    end

endmodule
